// File: rtl/mapu_b_pkg.sv
// -----------------------------------------------------------------------------
// mapu_b_pkg
// Shared constants and types for the Matrix APU block (mapu_b_modport).
//   N              : matrix dimension (3x3)
//   DATA_WIDTH_DEF : default element width
//   op_e           : operation select (add / multiply)
//   state_e        : control FSM states
//   mat_t          : 3x3 element array at the default width; modules with a
//                    different DATA_WIDTH declare the same shape locally.
// -----------------------------------------------------------------------------
package mapu_b_pkg;

    localparam int N              = 3;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        OUTPUT
    } state_e;

    // Indexed as m[row][col].
    typedef logic [N-1:0][N-1:0][DATA_WIDTH_DEF-1:0] mat_t;

endpackage

// File: rtl/mapu_b_modport_if.sv
// -----------------------------------------------------------------------------
// mapu_b_modport_if
// Data-plane streams and static control plane of the Matrix APU block.
//   Input stream : i_vld, o_rdy, i_r0/i_r1/i_r2 (one matrix column per beat)
//   Output stream: o_vld, i_rdy, o_r0/o_r1/o_r2 (one result column per beat)
//   Control      : i_en (enable), i_op (0 add, 1 multiply), o_of (overflow)
// Modports:
//   slave  : the block itself
//   master : the environment driving the block
// -----------------------------------------------------------------------------
interface mapu_b_modport_if
    import mapu_b_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  i_vld;
    logic                  o_rdy;
    logic [DATA_WIDTH-1:0] i_r0;
    logic [DATA_WIDTH-1:0] i_r1;
    logic [DATA_WIDTH-1:0] i_r2;

    logic                  o_vld;
    logic                  i_rdy;
    logic [DATA_WIDTH-1:0] o_r0;
    logic [DATA_WIDTH-1:0] o_r1;
    logic [DATA_WIDTH-1:0] o_r2;

    logic                  i_en;
    logic                  i_op;
    logic                  o_of;

    modport slave (
        input  i_vld, i_r0, i_r1, i_r2, i_rdy, i_en, i_op,
        output o_rdy, o_vld, o_r0, o_r1, o_r2, o_of
    );

    modport master (
        output i_vld, i_r0, i_r1, i_r2, i_rdy, i_en, i_op,
        input  o_rdy, o_vld, o_r0, o_r1, o_r2, o_of
    );

endinterface

// File: rtl/mapu_b_alu.sv
// -----------------------------------------------------------------------------
// mapu_b_alu
// Purely combinational 3x3 matrix add / multiply.
//   a, b : operand matrices, indexed [row][col]
//   op   : OP_ADD -> C = A + B, OP_MUL -> C = A * B
//   c    : result truncated to DATA_WIDTH per element
//   of   : set when any element's full-width result does not fit DATA_WIDTH
// -----------------------------------------------------------------------------
module mapu_b_alu
    import mapu_b_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)
(
    input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] a,
    input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] b,
    input  op_e                                 op,
    output logic [N-1:0][N-1:0][DATA_WIDTH-1:0] c,
    output logic                                of
);

    // Wide enough for a sum of three full products.
    localparam int FW = 2 * DATA_WIDTH + 2;

    logic [FW-1:0] acc;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        c   = '0;
        of  = 1'b0;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (op == OP_MUL) begin
                    acc = '0;
                    for (int k = 0; k < N; k++) begin
                        acc = acc + FW'(a[i][k]) * FW'(b[k][j]);
                    end
                end else begin
                    acc = FW'(a[i][j]) + FW'(b[i][j]);
                end
                c[i][j] = acc[DATA_WIDTH-1:0];
                if (acc[FW-1:DATA_WIDTH] != '0) begin
                    of = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mapu_b_modport.sv
// -----------------------------------------------------------------------------
// mapu_b_modport
// Matrix APU block: loads A then B column by column over the input stream,
// computes A+B or A*B in one cycle, and returns C column by column over the
// output stream with an overflow flag.
//   clk     : rising-edge clock
//   reset_n : asynchronous reset, active HIGH despite the name
//   bus     : mapu_b_modport_if.slave (streams + enable/op/overflow)
// -----------------------------------------------------------------------------
module mapu_b_modport
    import mapu_b_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)
(
    input  logic               clk,
    input  logic               reset_n,
    mapu_b_modport_if.slave    bus
);

    typedef logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mat_w_t;

    localparam logic [1:0] LAST_BEAT = 2'(N - 1);

    state_e                state_q, state_d;
    logic [1:0]            cnt_q,   cnt_d;
    op_e                   op_q,    op_d;
    mat_w_t                a_q,     a_d;
    mat_w_t                b_q,     b_d;
    logic                  of_q,    of_d;
    logic                  vld_q,   vld_d;
    logic [DATA_WIDTH-1:0] r0_q,    r0_d;
    logic [DATA_WIDTH-1:0] r1_q,    r1_d;
    logic [DATA_WIDTH-1:0] r2_q,    r2_d;

    mat_w_t     alu_c;
    logic       alu_of;
    logic       rdy;
    logic       in_xfer;
    logic       out_xfer;
    logic [1:0] cnt_nxt;

    // A and B stay untouched from COMPUTE through OUTPUT, so later result
    // columns are read straight from the ALU rather than from a C register.
    mapu_b_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .c  (alu_c),
        .of (alu_of)
    );

    assign rdy      = bus.i_en & ((state_q == LOAD_A) | (state_q == LOAD_B));
    assign in_xfer  = bus.i_vld & rdy;
    assign out_xfer = vld_q & bus.i_rdy;
    assign cnt_nxt  = cnt_q + 2'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        of_d    = of_q;
        vld_d   = vld_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        r2_d    = r2_q;

        case (state_q)
            IDLE: begin
                if (bus.i_en) state_d = LOAD_A;
            end

            LOAD_A: begin
                if (!bus.i_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (in_xfer) begin
                    a_d[0][cnt_q] = bus.i_r0;
                    a_d[1][cnt_q] = bus.i_r1;
                    a_d[2][cnt_q] = bus.i_r2;
                    if (cnt_q == 2'd0) op_d = op_e'(bus.i_op);
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end

            LOAD_B: begin
                if (!bus.i_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (in_xfer) begin
                    b_d[0][cnt_q] = bus.i_r0;
                    b_d[1][cnt_q] = bus.i_r1;
                    b_d[2][cnt_q] = bus.i_r2;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end

            COMPUTE: begin
                of_d    = alu_of;
                vld_d   = 1'b1;
                r0_d    = alu_c[0][0];
                r1_d    = alu_c[1][0];
                r2_d    = alu_c[2][0];
                cnt_d   = '0;
                state_d = OUTPUT;
            end

            OUTPUT: begin
                if (out_xfer) begin
                    if (cnt_q == LAST_BEAT) begin
                        vld_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = bus.i_en ? LOAD_A : IDLE;
                    end else begin
                        cnt_d = cnt_nxt;
                        r0_d  = alu_c[0][cnt_nxt];
                        r1_d  = alu_c[1][cnt_nxt];
                        r2_d  = alu_c[2][cnt_nxt];
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            // NOTE: the operand storage is reset along with the control
            // state, so nothing from an interrupted operation survives reset.
            a_q     <= '0;
            b_q     <= '0;
            of_q    <= 1'b0;
            vld_q   <= 1'b0;
            r0_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its _d, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            of_q    <= of_d;
            vld_q   <= vld_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
        end
    end

    assign bus.o_rdy = rdy;
    assign bus.o_vld = vld_q;
    assign bus.o_r0  = r0_q;
    assign bus.o_r1  = r1_q;
    assign bus.o_r2  = r2_q;
    assign bus.o_of  = of_q;

endmodule

// File: tb/tb_mapu_b_modport.sv
// -----------------------------------------------------------------------------
// tb_mapu_b_modport
// Directed self-checking bench for mapu_b_modport: add, multiply, overflow,
// output backpressure, enable abort and reset in the middle of an output.
// -----------------------------------------------------------------------------
module tb_mapu_b_modport;
    import mapu_b_pkg::*;

    localparam int DW = DATA_WIDTH_DEF;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mapu_b_modport_if #(.DATA_WIDTH(DW)) bus ();

    mapu_b_modport #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (rst),
        .bus     (bus)
    );

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic mat_t fill(input logic [DW-1:0] v);
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = v;
        return m;
    endfunction

    // [1 2 3; 4 5 6; 7 8 9]
    function automatic mat_t seq_mat();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = DW'(3 * i + j + 1);
        return m;
    endfunction

    function automatic mat_t ident();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = (i == j) ? DW'(1) : DW'(0);
        return m;
    endfunction

    task automatic send_beat(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                             input logic [DW-1:0] r2);
        int n;
        n = 0;
        bus.i_vld = 1'b1;
        bus.i_r0  = r0;
        bus.i_r1  = r1;
        bus.i_r2  = r2;
        while (!bus.o_rdy && n < 20) begin
            step();
            n++;
        end
        if (!bus.o_rdy) check("in_rdy_timeout", 64'd0, 64'd1);
        step();
    endtask

    task automatic send_matrix(input mat_t m);
        for (int k = 0; k < N; k++) send_beat(m[0][k], m[1][k], m[2][k]);
        bus.i_vld = 1'b0;
    endtask

    task automatic recv_cols(input string name, input mat_t c, input logic of,
                             input int first, input int last);
        int n;
        for (int k = first; k <= last; k++) begin
            n = 0;
            while (!bus.o_vld && n < 20) begin
                step();
                n++;
            end
            check($sformatf("%s_vld_c%0d", name, k), 64'(bus.o_vld), 64'd1);
            check($sformatf("%s_r0_c%0d", name, k), 64'(bus.o_r0), 64'(c[0][k]));
            check($sformatf("%s_r1_c%0d", name, k), 64'(bus.o_r1), 64'(c[1][k]));
            check($sformatf("%s_r2_c%0d", name, k), 64'(bus.o_r2), 64'(c[2][k]));
            check($sformatf("%s_of_c%0d", name, k), 64'(bus.o_of), 64'(of));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t a, b, e;

        rst       = 1'b1;
        bus.i_vld = 1'b0;
        bus.i_r0  = '0;
        bus.i_r1  = '0;
        bus.i_r2  = '0;
        bus.i_rdy = 1'b1;
        bus.i_en  = 1'b0;
        bus.i_op  = 1'b0;
        #12;

        // Reset state
        check("rst_vld", 64'(bus.o_vld), 64'd0);
        check("rst_rdy", 64'(bus.o_rdy), 64'd0);
        check("rst_of",  64'(bus.o_of),  64'd0);
        check("rst_r0",  64'(bus.o_r0),  64'd0);
        check("rst_r2",  64'(bus.o_r2),  64'd0);
        @(negedge clk);
        rst      = 1'b0;
        bus.i_en = 1'b1;
        step();

        // Add, no overflow; latency: COMPUTE right after the last B beat
        bus.i_op = 1'b0;
        send_matrix(fill(DW'(1)));
        send_matrix(fill(DW'(2)));
        check("lat_vld_compute", 64'(bus.o_vld), 64'd0);
        check("lat_rdy_compute", 64'(bus.o_rdy), 64'd0);
        step();
        check("lat_vld_first", 64'(bus.o_vld), 64'd1);
        recv_cols("add", fill(DW'(3)), 1'b0, 0, 2);
        check("add_vld_drop", 64'(bus.o_vld), 64'd0);

        // Multiply identity * B = B; op changes after A are ignored
        bus.i_op = 1'b1;
        send_matrix(ident());
        bus.i_op = 1'b0;
        send_matrix(seq_mat());
        recv_cols("mul_id", seq_mat(), 1'b0, 0, 2);

        // Multiply B * B
        bus.i_op = 1'b1;
        send_matrix(seq_mat());
        send_matrix(seq_mat());
        e[0][0] = 30;  e[0][1] = 36;  e[0][2] = 42;
        e[1][0] = 66;  e[1][1] = 81;  e[1][2] = 96;
        e[2][0] = 102; e[2][1] = 126; e[2][2] = 150;
        recv_cols("mul_sq", e, 1'b0, 0, 2);

        // Add overflow
        bus.i_op = 1'b0;
        a = fill(DW'(0)); a[0][0] = 32'hFFFF_FFFF;
        b = fill(DW'(0)); b[0][0] = 32'd1;
        send_matrix(a);
        send_matrix(b);
        recv_cols("add_of", fill(DW'(0)), 1'b1, 0, 2);

        // Multiply overflow: 2^16 * 2^16 wraps to 0
        bus.i_op = 1'b1;
        a = fill(DW'(0)); a[0][0] = 32'h0001_0000;
        b = fill(DW'(0)); b[0][0] = 32'h0001_0000;
        send_matrix(a);
        send_matrix(b);
        recv_cols("mul_of", fill(DW'(0)), 1'b1, 0, 2);

        // Clean op clears overflow
        bus.i_op = 1'b0;
        send_matrix(fill(DW'(1)));
        send_matrix(fill(DW'(2)));
        recv_cols("of_clr", fill(DW'(3)), 1'b0, 0, 2);

        // Backpressure on result column 1
        bus.i_op = 1'b0;
        send_matrix(seq_mat());
        send_matrix(fill(DW'(0)));
        recv_cols("bp", seq_mat(), 1'b0, 0, 0);
        bus.i_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("bp_hold_vld_%0d", c), 64'(bus.o_vld), 64'd1);
            check($sformatf("bp_hold_r0_%0d", c),  64'(bus.o_r0),  64'd2);
            check($sformatf("bp_hold_r1_%0d", c),  64'(bus.o_r1),  64'd5);
            check($sformatf("bp_hold_r2_%0d", c),  64'(bus.o_r2),  64'd8);
            check($sformatf("bp_hold_rdy_%0d", c), 64'(bus.o_rdy), 64'd0);
        end
        bus.i_rdy = 1'b1;
        recv_cols("bp", seq_mat(), 1'b0, 1, 2);

        // Enable abort after 4 input beats
        bus.i_op = 1'b0;
        send_matrix(fill(DW'(1)));
        send_beat(DW'(9), DW'(9), DW'(9));
        bus.i_vld = 1'b0;
        bus.i_en  = 1'b0;
        #1;
        check("abort_rdy_now", 64'(bus.o_rdy), 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("abort_vld_%0d", c), 64'(bus.o_vld), 64'd0);
            check($sformatf("abort_rdy_%0d", c), 64'(bus.o_rdy), 64'd0);
        end
        bus.i_en = 1'b1;
        bus.i_op = 1'b1;
        send_matrix(seq_mat());
        send_matrix(ident());
        recv_cols("reload", seq_mat(), 1'b0, 0, 2);

        // Reset during result beat 1 (overflowing op so o_of is 1 beforehand)
        bus.i_op = 1'b0;
        a = fill(DW'(1)); a[0][0] = 32'hFFFF_FFFF;
        send_matrix(a);
        send_matrix(fill(DW'(1)));
        e = fill(DW'(2)); e[0][0] = 32'd0;
        recv_cols("pre_rst", e, 1'b1, 0, 0);
        check("pre_rst_r0_c1", 64'(bus.o_r0), 64'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 64'(bus.o_vld), 64'd0);
        check("mid_rst_r0",  64'(bus.o_r0),  64'd0);
        check("mid_rst_r1",  64'(bus.o_r1),  64'd0);
        check("mid_rst_r2",  64'(bus.o_r2),  64'd0);
        check("mid_rst_of",  64'(bus.o_of),  64'd0);
        check("mid_rst_rdy", 64'(bus.o_rdy), 64'd0);
        step();
        rst = 1'b0;
        send_matrix(fill(DW'(1)));
        send_matrix(fill(DW'(2)));
        recv_cols("post_rst", fill(DW'(3)), 1'b0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/mapu_b_modport.md
Name: mapu_b_modport

Overview:
Matrix APU block. It accepts two 3x3 matrices of unsigned DATA_WIDTH-bit elements over a valid/ready input stream and computes their sum or product. The 3x3 result is returned over a valid/ready output stream, with an overflow flag. It sits behind the Matrix APU data-plane input and output streams and is controlled by a static enable/op control plane.

Parameters:
- DATA_WIDTH, 32, width of one matrix element; each row port carries one element.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  system reset; asynchronous, active-high (asserted when 1), port name kept per codebase
- i_vld  in  1  input beat valid
- o_rdy  out  1  block ready to accept input beat
- i_r0/i_r1/i_r2  in  DATA_WIDTH each  elements row 0/1/2 of the current input column
- o_vld  out  1  output beat valid
- i_rdy  in  1  downstream ready for output beat
- o_r0/o_r1/o_r2  out  DATA_WIDTH each  elements row 0/1/2 of the current result column
- i_en  in  1  block enable
- i_op  in  1  operation: 0 = add, 1 = multiply
- o_of  out  1  overflow flag of the current/last result

Behaviour:
- Beat format: a beat transfers one matrix column k (k = 0, 1, 2 in order): r0 = M[0][k], r1 = M[1][k], r2 = M[2][k]. A matrix takes 3 beats.
- An input transfer occurs on a rising edge with i_vld & o_rdy. An output transfer occurs on a rising edge with o_vld & i_rdy.
- State machine:
  - IDLE -> LOAD_A on i_en.
  - LOAD_A: 3 beats of A. i_op is latched on A's first beat.
  - LOAD_B: 3 beats of B.
  - COMPUTE: 1 cycle.
  - OUTPUT: 3 beats of C.
  - Then back to LOAD_A if i_en, else IDLE.
- o_rdy = i_en & (state is LOAD_A or LOAD_B). It is combinational from the state register and i_en.
- Add: C[i][j] = A[i][j] + B[i][j].
- Multiply: C[i][j] = sum over k of A[i][k]*B[k][j], computed at full width 2*DATA_WIDTH+2.
- Results are truncated to DATA_WIDTH (wrap modulo 2^DATA_WIDTH).
- Overflow: o_of is set in COMPUTE if any element's full-width result exceeds 2^DATA_WIDTH-1. It is held through OUTPUT and until the next COMPUTE.
- Latency: last B beat accepted at edge T -> COMPUTE during cycle T..T+1 -> o_vld high after edge T+1, with column 0 on o_r*.
- Output registers: o_vld and o_r* are registered. While o_vld & !i_rdy, o_r* and o_of hold stable. The column index advances only on an accepted output beat.
- o_rdy is 0 throughout COMPUTE and OUTPUT; no input overlap.
- i_en deasserted in LOAD_A or LOAD_B: partial data is discarded, the FSM returns to IDLE, and o_rdy drops the same cycle.
- i_en deasserted in COMPUTE or OUTPUT: the result completes and drains normally, then the FSM returns to IDLE.
- i_op changes after A's first beat are ignored for that operation.
- reset_n asserted at any time, including mid-load or mid-output: immediately state = IDLE, o_rdy = 0, o_vld = 0, o_r0/o_r1/o_r2 = 0, o_of = 0, beat counters = 0, and all stored matrices are cleared.

Decomposition:
- Package mapu_b_pkg holds:
  - constant N = 3
  - op enum: OP_ADD = 0, OP_MUL = 1
  - FSM state enum: IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT
  - a parameterised 3x3 element array typedef
- One sub-module, mapu_b_alu: purely combinational. Inputs are A, B and op; outputs are the truncated C and an overflow flag. The top module holds the FSM, counters, matrix storage and output registers.

Test Plan:
- Add, no overflow: A all 1, B all 2, op = 0, i_rdy = 1 -> 3 output beats, each with o_r0/o_r1/o_r2 = 3; o_of = 0; first o_vld 2 cycles after the last input beat.
- Multiply: A = identity, B = [1 2 3; 4 5 6; 7 8 9], op = 1 -> output beats (1,4,7), (2,5,8), (3,6,9); o_of = 0.
- Overflow: op = 0, A[0][0] = 0xFFFFFFFF, B[0][0] = 1, rest 0 -> C[0][0] = 0, o_of = 1 held through all 3 output beats; the next clean operation clears o_of.
- Backpressure: i_rdy = 0 for 5 cycles on result column 1 -> o_vld stays 1 and o_r* stay stable; column 2 follows only after the accepted beat; o_rdy = 0 throughout.
- Enable abort: i_en dropped after 4 input beats -> o_rdy = 0 immediately, no o_vld. After re-enable, a fresh 6-beat load produces the correct result.
- Reset mid-output: assert reset_n during result beat 1 -> o_vld, o_r*, o_of = 0 immediately; after release, a full new operation computes correctly.
